// File: rtl/button_encoder.sv
// Player-side button front end. Eight raw buttons are synchronised and debounced.
// A clean single-button press is then encoded into a 3-bit symbol with a one-cycle
// btn_valid strobe. Multi-button presses are rejected with a multi_press strobe.
// A debounced release is required before the next press is accepted.
module button_encoder #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] btn,
   output logic [2:0] btn_code,
   output logic       btn_valid,
   output logic       multi_press,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [7:0]       sync_a;
   logic [7:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]       cand;
   logic [2:0]       cand_next;
   logic [2:0]       code_next;
   logic             valid_next;
   logic             multi_next;
   logic             one_hot;
   logic             several;
   logic             match;
   logic             cnt_done;
   logic [2:0]       sync_idx;

   // Two-flop synchroniser per button; it keeps running whether or not the encoder is enabled
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= '0;
         sync   <= '0;
      end else begin
         sync_a <= btn;
         sync   <= sync_a;
      end
   end

   // Classify the synchronised buttons: single press, several at once, or still the candidate
   always_comb begin
      one_hot  = (sync != 8'd0) && ((sync & (sync - 8'd1)) == 8'd0);
      several  = (sync != 8'd0) && !one_hot;
      match    = (sync == (8'd1 << cand));
      cnt_done = (cnt == CNT_LAST);
      sync_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (sync[i]) begin
            sync_idx = 3'(i);
         end
      end
   end

   // State register together with the counter, candidate and registered output strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cand        <= 3'd0;
         btn_code    <= 3'd0;
         btn_valid   <= 1'b0;
         multi_press <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         cand        <= cand_next;
         btn_code    <= code_next;
         btn_valid   <= valid_next;
         multi_press <= multi_next;
      end
   end

   // Next-state logic; dropping enable parks the encoder in IDLE with a cleared counter
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cand_next  = cand;
      if (!en) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (one_hot) begin
                  cand_next  = sync_idx;
                  cnt_next   = '0;
                  state_next = DEBOUNCE;
               end else if (several) begin
                  state_next = HELD;
               end
            end
            DEBOUNCE: begin
               if (match) begin
                  if (cnt_done) begin
                     state_next = HELD;
                  end else begin
                     cnt_next = cnt + 1'b1;
                  end
               end else begin
                  state_next = IDLE;
               end
            end
            HELD: begin
               if (sync == 8'd0) begin
                  cnt_next   = '0;
                  state_next = RELEASE;
               end
            end
            RELEASE: begin
               if (sync != 8'd0) begin
                  state_next = HELD;
               end else if (cnt_done) begin
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Output logic; the strobes are one-shot because their source states are left on the same edge
   always_comb begin
      code_next  = btn_code;
      valid_next = 1'b0;
      multi_next = 1'b0;
      busy       = (state != IDLE);
      if (en) begin
         if ((state == DEBOUNCE) && match && cnt_done) begin
            valid_next = 1'b1;
            code_next  = cand;
         end
         if ((state == IDLE) && several) begin
            multi_next = 1'b1;
         end
      end
   end

endmodule
